// File: rtl/operand_feeder.sv
// Operand buffer feeding one MAC edge input: loads up to DEPTH operands, then streams them
// with a skew delay and a post-beat gap. Define FEEDER_REPLAY_EN to keep the vector for replay.
module operand_feeder #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned SKEW       = 0,
  parameter int unsigned GAP        = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_full,
  input  logic                  start,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_waiting,
  input  logic                  out_ready,
  output logic                  out_finished
);

  localparam int unsigned PTR_W     = $clog2(DEPTH) + 1;
  localparam int unsigned IDX_W     = $clog2(DEPTH);
  localparam int unsigned SKEW_W    = $clog2(SKEW + 2);
  localparam int unsigned GAP_W     = $clog2(GAP + 1);
  localparam int unsigned SKEW_LAST = (SKEW > 0) ? SKEW - 1 : 0;
  localparam int unsigned GAP_LAST  = GAP - 1;

  typedef enum logic [2:0] {StIdle, StSkew, StStream, StGap, StFinish} state_e;

  state_e                state_q, state_d;
  logic [PTR_W-1:0]      wr_cnt_q, wr_cnt_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [SKEW_W-1:0]     skew_cnt_q, skew_cnt_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_waiting_q, out_waiting_d;
  logic                  out_finished_q, out_finished_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  wr_accept;
  logic [IDX_W-1:0]      wr_idx;

`ifdef FEEDER_REPLAY_EN
  // Set after FINISH: the kept vector is replayable until the next write starts a new one.
  logic fresh_q, fresh_d;
  assign wr_full = (wr_cnt_q == PTR_W'(DEPTH)) & ~fresh_q;
`else
  assign wr_full = (wr_cnt_q == PTR_W'(DEPTH));
`endif

  assign busy         = (state_q != StIdle);
  assign out_data     = out_data_q;
  assign out_waiting  = out_waiting_q;
  assign out_finished = out_finished_q;

  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    skew_cnt_d = skew_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    wr_accept  = 1'b0;
    wr_idx     = wr_cnt_q[IDX_W-1:0];
`ifdef FEEDER_REPLAY_EN
    fresh_d    = fresh_q;
`endif

    unique case (state_q)
      StIdle: begin
`ifdef FEEDER_REPLAY_EN
        if (wr_en && fresh_q) begin
          wr_accept = 1'b1;
          wr_idx    = '0;
          wr_cnt_d  = PTR_W'(1);
          fresh_d   = 1'b0;
        end else if (wr_en && !wr_full) begin
          wr_accept = 1'b1;
          wr_cnt_d  = wr_cnt_q + PTR_W'(1);
        end
`else
        if (wr_en && !wr_full) begin
          wr_accept = 1'b1;
          wr_cnt_d  = wr_cnt_q + PTR_W'(1);
        end
`endif
        if (start && ((wr_cnt_q != '0) || wr_en)) begin
          skew_cnt_d = '0;
          if (SKEW == 0) state_d = StStream;
          else           state_d = StSkew;
        end
      end
      StSkew: begin
        if (skew_cnt_q == SKEW_W'(SKEW_LAST)) state_d = StStream;
        else skew_cnt_d = skew_cnt_q + SKEW_W'(1);
      end
      StStream: begin
        if (out_waiting_q && out_ready) begin
          rd_ptr_d  = rd_ptr_q + PTR_W'(1);
          gap_cnt_d = '0;
          state_d   = StGap;
        end
      end
      StGap: begin
        if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
          if (rd_ptr_q < wr_cnt_q) state_d = StStream;
          else                     state_d = StFinish;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      StFinish: begin
        state_d  = StIdle;
        rd_ptr_d = '0;
`ifdef FEEDER_REPLAY_EN
        fresh_d  = 1'b1;
`else
        wr_cnt_d = '0;
`endif
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered, so they are decoded from the next state.
    out_waiting_d  = (state_d == StStream);
    out_finished_d = (state_d == StFinish);
    case (state_d)
      StStream: begin
        // Forward a same-cycle write so start+wr_en with SKEW==0 presents the new operand.
        if (wr_accept && (wr_idx == rd_ptr_d[IDX_W-1:0])) out_data_d = wr_data;
        else                                             out_data_d = mem_q[rd_ptr_d[IDX_W-1:0]];
      end
      StGap:   out_data_d = out_data_q;
      default: out_data_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      wr_cnt_q       <= '0;
      rd_ptr_q       <= '0;
      skew_cnt_q     <= '0;
      gap_cnt_q      <= '0;
      out_data_q     <= '0;
      out_waiting_q  <= 1'b0;
      out_finished_q <= 1'b0;
`ifdef FEEDER_REPLAY_EN
      fresh_q        <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      wr_cnt_q       <= wr_cnt_d;
      rd_ptr_q       <= rd_ptr_d;
      skew_cnt_q     <= skew_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      out_data_q     <= out_data_d;
      out_waiting_q  <= out_waiting_d;
      out_finished_q <= out_finished_d;
`ifdef FEEDER_REPLAY_EN
      fresh_q        <= fresh_d;
`endif
    end
  end

  // Buffer contents need no reset: wr_cnt alone defines what is valid.
  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wr_idx] <= wr_data;
  end

endmodule

// File: tb/tb_operand_feeder.sv
// Self-checking bench for operand_feeder: scoreboard of loaded operands checked on every beat,
// plus per-scenario timing checks. One DUT with SKEW=0, a second with SKEW=4 for skew timing.
module tb_operand_feeder;

  localparam int unsigned DW     = 32;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned GAP    = 2;
  localparam int unsigned SKEW_S = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en, start, out_ready;
  logic [DW-1:0] wr_data;
  logic          wr_full, busy, out_waiting, out_finished;
  logic [DW-1:0] out_data;

  logic          wr_en_s, start_s, out_ready_s;
  logic [DW-1:0] wr_data_s;
  logic          wr_full_s, busy_s, out_waiting_s, out_finished_s;
  logic [DW-1:0] out_data_s;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            mon_beats = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mon_exp;

  always #5 clk = ~clk;

  operand_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .SKEW(0), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
    .start(start), .busy(busy), .out_data(out_data), .out_waiting(out_waiting),
    .out_ready(out_ready), .out_finished(out_finished)
  );

  operand_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .SKEW(SKEW_S), .GAP(GAP)) dut_s (
    .clk(clk), .rst(rst), .wr_en(wr_en_s), .wr_data(wr_data_s), .wr_full(wr_full_s),
    .start(start_s), .busy(busy_s), .out_data(out_data_s), .out_waiting(out_waiting_s),
    .out_ready(out_ready_s), .out_finished(out_finished_s)
  );

  // Scoreboard: a beat happens at the coming posedge when waiting & ready are high now.
  always @(negedge clk) begin
    if (!rst && out_waiting && out_ready) begin
      mon_beats++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL beat_unexpected: got %h, want no beat", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out_data !== mon_exp) begin
          n_fail++;
          $display("FAIL beat_data: got %h, want %h", out_data, mon_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [DW-1:0] v);
    wr_en   = 1'b1;
    wr_data = v;
    exp_q.push_back(v);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_drain_timeout: got busy=%b, want 0", name, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks += 7;
    if (out_data !== '0)       begin n_fail++; $display("FAIL reset_out_data: got %h, want 0", out_data); end
    if (out_waiting !== 1'b0)  begin n_fail++; $display("FAIL reset_out_waiting: got %b, want 0", out_waiting); end
    if (out_finished !== 1'b0) begin n_fail++; $display("FAIL reset_out_finished: got %b, want 0", out_finished); end
    if (busy !== 1'b0)         begin n_fail++; $display("FAIL reset_busy: got %b, want 0", busy); end
    if (wr_full !== 1'b0)      begin n_fail++; $display("FAIL reset_wr_full: got %b, want 0", wr_full); end
    if (busy_s !== 1'b0)       begin n_fail++; $display("FAIL reset_busy_s: got %b, want 0", busy_s); end
    if (out_waiting_s !== 1'b0) begin n_fail++; $display("FAIL reset_waiting_s: got %b, want 0", out_waiting_s); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int beats = 0, last_beat = -100, bad_space = 0, fin_cnt = 0, fin_at = -100;
    logic busy_after = 1'b1;
    logic [DW-1:0] fin_data = '1;
    mon_beats = 0;
    load(3); load(5); load(7);
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (out_waiting !== 1'b1) begin n_fail++; $display("FAIL basic_first_waiting: got %b, want 1", out_waiting); end
    for (int i = 0; i < 40; i++) begin
      if (out_waiting && out_ready) begin
        if (beats > 0 && (i - last_beat) != GAP + 1) bad_space++;
        beats++;
        last_beat = i;
      end
      if (out_finished) begin fin_cnt++; fin_at = i; fin_data = out_data; end
      if (i == fin_at + 1) busy_after = busy;
      tick();
    end
    n_checks += 7;
    if (beats != 3)     begin n_fail++; $display("FAIL basic_beats: got %0d, want 3", beats); end
    if (bad_space != 0) begin n_fail++; $display("FAIL basic_spacing: got %0d bad gaps, want 0", bad_space); end
    if (fin_cnt != 1)   begin n_fail++; $display("FAIL basic_finish_count: got %0d, want 1", fin_cnt); end
    if (fin_at != last_beat + int'(GAP) + 1)
      begin n_fail++; $display("FAIL basic_finish_time: got %0d, want %0d", fin_at, last_beat + GAP + 1); end
    if (fin_data !== '0) begin n_fail++; $display("FAIL basic_finish_data: got %h, want 0", fin_data); end
    if (busy_after !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %b, want 0", busy_after); end
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL basic_queue: got %0d left, want 0", exp_q.size()); end
  endtask

  task automatic test_skew();
    int first = -1, fin_cnt = 0;
    logic [DW-1:0] first_data = '0;
    logic busy1 = 1'b0;
    out_ready_s = 1'b1;
    wr_en_s = 1'b1;
    wr_data_s = 32'h11;
    tick();
    wr_en_s = 1'b0;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 1) busy1 = busy_s;
      if (out_waiting_s && first < 0) begin first = k; first_data = out_data_s; end
      if (out_finished_s) fin_cnt++;
      tick();
    end
    n_checks += 5;
    if (first != SKEW_S + 1) begin n_fail++; $display("FAIL skew_first_waiting: got %0d, want %0d", first, SKEW_S + 1); end
    if (first_data !== 32'h11) begin n_fail++; $display("FAIL skew_data: got %h, want 11", first_data); end
    if (busy1 !== 1'b1)  begin n_fail++; $display("FAIL skew_busy: got %b, want 1", busy1); end
    if (fin_cnt != 1)    begin n_fail++; $display("FAIL skew_finish: got %0d, want 1", fin_cnt); end
    if (busy_s !== 1'b0) begin n_fail++; $display("FAIL skew_idle: got %b, want 0", busy_s); end
  endtask

  task automatic test_stall();
    int waited = 0, bad = 0;
    logic [DW-1:0] held;
    mon_beats = 0;
    load(32'hA1); load(32'hB2); load(32'hC3); load(32'hD4);
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    out_ready = 1'b0;
    while (!out_waiting && waited < 20) begin tick(); waited++; end
    held = out_data;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_waiting !== 1'b1 || out_data !== held) bad++;
    end
    n_checks += 2;
    if (held !== 32'hB2) begin n_fail++; $display("FAIL stall_held_data: got %h, want b2", held); end
    if (bad != 0) begin n_fail++; $display("FAIL stall_stable: got %0d unstable cycles, want 0", bad); end
    out_ready = 1'b1;
    drain("stall");
    n_checks += 2;
    if (mon_beats != 4) begin n_fail++; $display("FAIL stall_beats: got %0d, want 4", mon_beats); end
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL stall_queue: got %0d left, want 0", exp_q.size()); end
  endtask

  task automatic test_full();
    mon_beats = 0;
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      wr_en = 1'b1;
      wr_data = 32'h100 + i;
      if (i < DEPTH) exp_q.push_back(32'h100 + i);
      tick();
      if (i == DEPTH - 2) begin
        n_checks++;
        if (wr_full !== 1'b0) begin n_fail++; $display("FAIL full_early: got %b, want 0", wr_full); end
      end
      if (i == DEPTH - 1) begin
        n_checks++;
        if (wr_full !== 1'b1) begin n_fail++; $display("FAIL full_set: got %b, want 1", wr_full); end
      end
    end
    wr_en = 1'b0;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    drain("full");
    n_checks += 2;
    if (mon_beats != DEPTH) begin n_fail++; $display("FAIL full_beats: got %0d, want %0d", mon_beats, DEPTH); end
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL full_queue: got %0d left, want 0", exp_q.size()); end
  endtask

  task automatic test_start_with_write();
    mon_beats = 0;
    out_ready = 1'b1;
    wr_en = 1'b1;
    wr_data = 32'h55;
    exp_q.push_back(32'h55);
    start = 1'b1;
    tick();
    wr_en = 1'b0;
    start = 1'b0;
    n_checks += 2;
    if (out_waiting !== 1'b1) begin n_fail++; $display("FAIL sw_waiting: got %b, want 1", out_waiting); end
    if (out_data !== 32'h55) begin n_fail++; $display("FAIL sw_data: got %h, want 55", out_data); end
    drain("sw");
    n_checks++;
    if (mon_beats != 1) begin n_fail++; $display("FAIL sw_beats: got %0d, want 1", mon_beats); end
  endtask

`ifdef FEEDER_REPLAY_EN
  task automatic test_replay();
    mon_beats = 0;
    out_ready = 1'b1;
    load(2); load(4);
    start = 1'b1; tick(); start = 1'b0;
    drain("replay_first");
    exp_q.push_back(2); exp_q.push_back(4);
    start = 1'b1; tick(); start = 1'b0;
    drain("replay_second");
    n_checks++;
    if (mon_beats != 4) begin n_fail++; $display("FAIL replay_beats: got %0d, want 4", mon_beats); end
    mon_beats = 0;
    load(9);
    start = 1'b1; tick(); start = 1'b0;
    drain("replay_new");
    n_checks += 2;
    if (mon_beats != 1) begin n_fail++; $display("FAIL replay_new_beats: got %0d, want 1", mon_beats); end
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL replay_queue: got %0d left, want 0", exp_q.size()); end
  endtask
`else
  task automatic test_empty_after_finish();
    int bad = 0;
    out_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (busy || out_waiting) bad++;
      tick();
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL empty_start_ignored: got %0d active cycles, want 0", bad); end
  endtask
`endif

  task automatic test_reset_mid();
    int bad = 0;
    mon_beats = 0;
    load(32'h31); load(32'h32); load(32'h33);
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    n_checks += 3;
    if (out_waiting !== 1'b0) begin n_fail++; $display("FAIL mid_gap_waiting: got %b, want 0", out_waiting); end
    if (out_data !== 32'h32) begin n_fail++; $display("FAIL mid_gap_data: got %h, want 32", out_data); end
    if (mon_beats != 2) begin n_fail++; $display("FAIL mid_beats: got %0d, want 2", mon_beats); end
    rst = 1'b1;
    tick();
    n_checks += 5;
    if (out_data !== '0)       begin n_fail++; $display("FAIL mid_rst_data: got %h, want 0", out_data); end
    if (out_waiting !== 1'b0)  begin n_fail++; $display("FAIL mid_rst_waiting: got %b, want 0", out_waiting); end
    if (out_finished !== 1'b0) begin n_fail++; $display("FAIL mid_rst_finished: got %b, want 0", out_finished); end
    if (busy !== 1'b0)         begin n_fail++; $display("FAIL mid_rst_busy: got %b, want 0", busy); end
    if (wr_full !== 1'b0)      begin n_fail++; $display("FAIL mid_rst_full: got %b, want 0", wr_full); end
    rst = 1'b0;
    exp_q.delete();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (busy || out_waiting || out_finished) bad++;
      tick();
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL mid_start_ignored: got %0d active cycles, want 0", bad); end
  endtask

  initial begin
    rst = 1'b1;
    wr_en = 1'b0; wr_data = '0; start = 1'b0; out_ready = 1'b0;
    wr_en_s = 1'b0; wr_data_s = '0; start_s = 1'b0; out_ready_s = 1'b0;
    test_reset();
    test_basic();
    test_skew();
    test_stall();
    test_full();
    test_start_with_write();
`ifdef FEEDER_REPLAY_EN
    test_replay();
`else
    test_empty_after_finish();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
